soc_reset_sequencer: RTL and testbench
======================================

SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning the clk_en period in clk cycles (legal range 1..256).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a button level.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the number of clk_en pulses soc_rst_n stays low after button release.
REQ-004 The block SHALL have parameter HEARTBEAT_PERIOD, default 50000000, meaning the clk cycles per heartbeat increment.
REQ-005 The block SHALL have parameter WDT_CYCLES, default 100000000, meaning the watchdog timeout in clk cycles.
REQ-006 The block SHALL have port clk, input, 1, the single system clock.
REQ-007 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-008 The block SHALL have port btn_n, input, 1, an asynchronous active-low reset button.
REQ-009 The block SHALL have port wdt_kick, input, 1, a watchdog kick pulse from the SOC.
REQ-010 The block SHALL have port clk_en, output, 1, a one-cycle enable pulse for the SOC.
REQ-011 The block SHALL have port soc_rst_n, output, 1, the SOC reset, active low.
REQ-012 The block SHALL have port ready, output, 1, high while the FSM is in RUN.
REQ-013 The block SHALL have port heartbeat, output, 8, a free-running activity counter.
REQ-014 The block SHALL have port wdt_fired, output, 1, a sticky watchdog-timeout flag.

Function
REQ-015 The block SHALL pass btn_n through a 2-flop synchronizer before any other use.
REQ-016 The debouncer SHALL update its level only after the synchronized input differs from that level for DEBOUNCE_CYCLES consecutive cycles; any intermediate bounce SHALL restart its counter at 0.
REQ-017 clk_en SHALL be high for exactly one cycle in every CLK_DIV cycles, or constantly high when CLK_DIV=1, and SHALL run in every FSM state.
REQ-018 The FSM SHALL have three states: PRESSED, HOLD and RUN.
REQ-019 In PRESSED the FSM SHALL drive soc_rst_n=0 and transition to HOLD when the debounced button reads released.
REQ-020 In HOLD the FSM SHALL keep soc_rst_n=0, count clk_en pulses, and transition to RUN on the cycle after the HOLD_CYCLES-th pulse.
REQ-021 In RUN the FSM SHALL drive soc_rst_n=1 and ready=1.
REQ-022 A debounced press in HOLD or RUN SHALL transition the FSM to PRESSED on the next cycle; a press takes priority over a simultaneous HOLD completion.
REQ-023 soc_rst_n and ready SHALL be registered outputs, changing one cycle after the state transition.
REQ-024 heartbeat SHALL increment by 1 every HEARTBEAT_PERIOD cycles in RUN only, wrap from 255 to 0, and clear to 0 on entry to PRESSED.

Reset
REQ-025 On rst=1 the block SHALL enter PRESSED with soc_rst_n=0, ready=0, clk_en=0, heartbeat=0, wdt_fired=0, all counters at 0, and debounced level=pressed.
REQ-026 rst asserted mid-HOLD or mid-RUN SHALL take effect on the next clk edge, overriding all other events.

Configuration
REQ-027 With macro SOC_WATCHDOG_EN defined, a counter in RUN SHALL clear on wdt_kick and, on reaching WDT_CYCLES, SHALL set wdt_fired and force the FSM to HOLD with the hold count restarted; wdt_fired SHALL clear only on rst.
REQ-028 With SOC_WATCHDOG_EN undefined, the block SHALL ignore wdt_kick, tie wdt_fired to 0, and contain no watchdog logic.

Verification
REQ-029 The bench SHALL cover: rst for 3 cycles, btn_n=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=4, CLK_DIV=2 -> soc_rst_n rises and ready=1 at a fixed cycle, with exactly 4 clk_en pulses counted in HOLD.
REQ-030 The bench SHALL cover: in RUN, btn_n low for 3 cycles and then high (bounce) -> no state change, soc_rst_n stays 1.
REQ-031 The bench SHALL cover: in RUN, btn_n low for 10 cycles -> PRESSED, soc_rst_n=0, heartbeat=0; then release -> HOLD followed by RUN.
REQ-032 The bench SHALL cover: HEARTBEAT_PERIOD=2 for 520 cycles in RUN -> heartbeat wraps 255 to 0 and reads 4.
REQ-033 The bench SHALL cover: with SOC_WATCHDOG_EN defined, WDT_CYCLES=20 and no kick -> wdt_fired=1, soc_rst_n=0 for 4 clk_en pulses, then RUN; with kicks every 10 cycles -> no timeout.
REQ-034 The bench SHALL cover: rst asserted in mid-HOLD -> PRESSED with all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/soc_reset_sequencer.sv
// Power-on/button reset sequencer: synchronizes and debounces btn_n, holds the SOC in reset
// for HOLD_CYCLES clk_en pulses after release, and runs a heartbeat. Define SOC_WATCHDOG_EN for the watchdog.
module soc_reset_sequencer #(
    parameter int CLK_DIV          = 2,
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int HOLD_CYCLES      = 16,
    parameter int HEARTBEAT_PERIOD = 50000000,
    parameter int WDT_CYCLES       = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       wdt_kick,
    output logic       clk_en,
    output logic       soc_rst_n,
    output logic       ready,
    output logic [7:0] heartbeat,
    output logic       wdt_fired
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HB_W   = (HEARTBEAT_PERIOD > 1) ? $clog2(HEARTBEAT_PERIOD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_PRESSED = 2'd0,
        S_HOLD    = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_deb_level;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_clk_en;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HB_W-1:0]   r_hb_div;
    logic [7:0]        r_heartbeat;
    logic              r_soc_rst_n;
    logic              r_ready;
    logic              w_press;
    logic              w_wdt_expire;

    // Reset values put the sync chain and the debounced level in the "pressed" state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_btn_meta <= btn_n;
            r_btn_sync <= r_btn_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_level <= 1'b0;
            r_deb_cnt   <= '0;
        end else if (r_btn_sync != r_deb_level) begin
            if (r_deb_cnt == DEB_LAST) begin
                r_deb_level <= r_btn_sync;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_clk_en  <= 1'b0;
        end else begin
            r_clk_en  <= (r_div_cnt == DIV_LAST);
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    assign w_press = ~r_deb_level;

`ifdef SOC_WATCHDOG_EN
    localparam int             WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt_fired;

    assign w_wdt_expire = (r_state == S_RUN) && !wdt_kick && (r_wdt_cnt == WDT_LAST);

    // A simultaneous button press wins, so the flag only records genuine timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt   <= '0;
            r_wdt_fired <= 1'b0;
        end else begin
            if (r_state != S_RUN || wdt_kick || r_wdt_cnt == WDT_LAST) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
            if (w_wdt_expire && !w_press) begin
                r_wdt_fired <= 1'b1;
            end
        end
    end

    assign wdt_fired = r_wdt_fired;
`else
    localparam int wdt_unused_cycles = WDT_CYCLES;
    logic w_unused_kick;

    assign w_unused_kick = wdt_kick;
    assign w_wdt_expire  = 1'b0;
    assign wdt_fired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_PRESSED;
            r_hold_cnt  <= '0;
            r_hb_div    <= '0;
            r_heartbeat <= 8'd0;
            r_soc_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_soc_rst_n <= (r_state == S_RUN);
            r_ready     <= (r_state == S_RUN);

            if (r_state == S_RUN) begin
                if (r_hb_div == HB_LAST) begin
                    r_hb_div    <= '0;
                    r_heartbeat <= r_heartbeat + 8'd1;
                end else begin
                    r_hb_div <= r_hb_div + 1'b1;
                end
            end else begin
                r_hb_div <= '0;
            end

            // Press handling comes last so its heartbeat clear overrides the increment.
            case (r_state)
                S_PRESSED: begin
                    r_hold_cnt <= '0;
                    if (!w_press) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_press) begin
                        r_state     <= S_PRESSED;
                        r_heartbeat <= 8'd0;
                    end else if (r_clk_en) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state    <= S_RUN;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_press) begin
                        r_state     <= S_PRESSED;
                        r_heartbeat <= 8'd0;
                    end else if (w_wdt_expire) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_PRESSED;
                end
            endcase
        end
    end

    assign clk_en    = r_clk_en;
    assign soc_rst_n = r_soc_rst_n;
    assign ready     = r_ready;
    assign heartbeat = r_heartbeat;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer: power-up sequence, bounce rejection, press/release,
// heartbeat wrap, watchdog (when SOC_WATCHDOG_EN is defined) and reset in mid-HOLD.
module tb_soc_reset_sequencer;
    localparam int HOLD = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_n    = 1'b1;
    logic       wdt_kick = 1'b1;
    logic       clk_en;
    logic       soc_rst_n;
    logic       ready;
    logic [7:0] heartbeat;
    logic       wdt_fired;

    int cyc     = 0;
    int err_cnt = 0;
    int chk_cnt = 0;

    soc_reset_sequencer #(
        .CLK_DIV         (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (HOLD),
        .HEARTBEAT_PERIOD(2),
        .WDT_CYCLES      (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .wdt_kick (wdt_kick),
        .clk_en   (clk_en),
        .soc_rst_n(soc_rst_n),
        .ready    (ready),
        .heartbeat(heartbeat),
        .wdt_fired(wdt_fired)
    );

    always #5 clk = ~clk;

    // Edge index since the last reset edge; clk_en is expected high after every even edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        chk_cnt++;
        if (got !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expected);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // HOLD entered at edge h: first counted pulse is the first even edge >= h,
    // the last is HOLD-1 pulses later, RUN one edge after that, ready one more.
    function automatic int exp_ready(input int h);
        int e1;
        e1 = (h % 2 == 0) ? h : h + 1;
        return e1 + 2 * HOLD;
    endfunction

    task automatic hold_phase(input int h, output int ready_edge, output int pulses);
        int exp_edge;
        exp_edge   = exp_ready(h);
        ready_edge = -1;
        pulses     = 0;
        for (int i = 0; i < 80; i++) begin
            if (clk_en && cyc >= h && cyc <= exp_edge - 2) pulses++;
            if (ready && cyc > h + 1) begin
                ready_edge = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int re;
        int pl;
        int h;
        int lows;
        int prev;
        int wrap;
        int k;
        int fe;

        // Reset for three edges with the button released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset soc_rst_n", soc_rst_n, 0);
        check("reset ready", ready, 0);
        check("reset clk_en", clk_en, 0);
        check("reset heartbeat", heartbeat, 0);
        check("reset wdt_fired", wdt_fired, 0);
        rst = 1'b0;

        // Power-up: debounce (4) after 2-flop sync -> HOLD at edge 7 -> ready at edge 16.
        hold_phase(7, re, pl);
        check("powerup ready edge", re, 16);
        check("powerup hold pulses", pl, 4);
        check("powerup soc_rst_n", soc_rst_n, 1);

        // Two 3-cycle bounces separated by a 1-cycle high: must not reach 4 consecutive.
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            btn_n = !((i < 3) || (i >= 4 && i < 7));
            @(negedge clk);
            if (!soc_rst_n || !ready) lows++;
        end
        check("bounce reset_low_cycles", lows, 0);
        check("bounce heartbeat nonzero", (heartbeat != 8'd0), 1);

        // Real press for 10 cycles, then release.
        btn_n = 1'b0;
        repeat (10) @(negedge clk);
        check("press soc_rst_n", soc_rst_n, 0);
        check("press ready", ready, 0);
        check("press heartbeat", heartbeat, 0);
        btn_n = 1'b1;
        h = cyc + 7;
        hold_phase(h, re, pl);
        check("release ready edge", re, exp_ready(h));
        check("release hold pulses", pl, 4);

        // 520 cycles in RUN at period 2: 260 increments, wraps once, reads 4.
        prev = heartbeat;
        wrap = 0;
        repeat (520) begin
            @(negedge clk);
            if (prev == 255 && heartbeat == 8'd0) wrap = 1;
            prev = heartbeat;
        end
        check("heartbeat wrap seen", wrap, 1);
        check("heartbeat value", heartbeat, 4);

`ifdef SOC_WATCHDOG_EN
        // No kick: timeout 20 cycles after the last kicked edge, then HOLD and back to RUN.
        wdt_kick = 1'b0;
        k  = cyc;
        fe = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wdt_fired) begin
                fe = cyc;
                break;
            end
        end
        check("wdt fire edge", fe, k + 20);
        h = cyc;
        @(negedge clk);
        check("wdt soc_rst_n low", soc_rst_n, 0);
        hold_phase(h, re, pl);
        check("wdt ready edge", re, exp_ready(h));
        check("wdt hold pulses", pl, 4);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            wdt_kick = (i % 10 == 0);
            @(negedge clk);
            if (!ready) lows++;
        end
        check("wdt kicked no_timeout", lows, 0);
        check("wdt sticky", wdt_fired, 1);
        wdt_kick = 1'b1;
`else
        wdt_kick = 1'b0;
        lows = 0;
        fe   = 0;
        repeat (40) begin
            @(negedge clk);
            if (!ready) lows++;
            if (wdt_fired) fe++;
        end
        check("nowdt ready held", lows, 0);
        check("nowdt wdt_fired", fe, 0);
        wdt_kick = 1'b1;
`endif

        // Reset asserted in mid-HOLD, just before an edge that would raise clk_en.
        btn_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        h = cyc + 7;
        while (!(cyc >= h + 1 && cyc % 2 == 1)) @(negedge clk);
        check("midhold soc_rst_n", soc_rst_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midhold rst soc_rst_n", soc_rst_n, 0);
        check("midhold rst ready", ready, 0);
        check("midhold rst clk_en", clk_en, 0);
        check("midhold rst heartbeat", heartbeat, 0);
        check("midhold rst wdt_fired", wdt_fired, 0);
        rst = 1'b0;
        hold_phase(7, re, pl);
        check("after rst ready edge", re, 16);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
